alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1: number of cycles (1..15) operands are held on the arithmetic port before the result is captured.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: block can accept a request.
REQ-006 SHALL have port opcode, input, 4: 0001 div, 0010 add, 0011 sub, 0100 mul; all others are illegal.
REQ-007 SHALL have ports a and b, input, 8 each: unsigned operands.
REQ-008 SHALL have port out_valid, output, 1: response present.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the response.
REQ-010 SHALL have port result, output, 16: captured result.
REQ-011 SHALL have port sign, output, 1: sub only; 1 when a<b, meaning result = b-a.
REQ-012 SHALL have port err, output, 1: illegal opcode, or divide-by-zero trap.
REQ-013 SHALL have ports arith_a and arith_b, output, 8 each: operands driven to the arithmetic unit.
REQ-014 SHALL have port arith_sel, output, 2: select lines; 00 div, 01 add, 10 sub, 11 mul.
REQ-015 SHALL have port arith_enable_low, output, 1: active-low enable for the arithmetic unit.
REQ-016 SHALL have port arith_y, input, 16: arithmetic unit result; tri-stated while the unit is disabled.

Function
REQ-017 SHALL implement the FSM states IDLE, DRIVE, CAPTURE and RESP.
REQ-018 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-019 On in_valid&&in_ready, the block SHALL latch opcode, a and b.
REQ-020 After the accept of REQ-019: an illegal opcode SHALL go to RESP with err=1 and result=0; otherwise the FSM SHALL go to DRIVE.
REQ-021 DRIVE SHALL last exactly SETTLE cycles, counted by a 4-bit counter, with arith_enable_low=0, arith_sel equal to opcode-1 (low 2 bits), and arith_a/arith_b equal to the latched operands.
REQ-022 CAPTURE SHALL last one cycle, with arith_enable_low still 0; on its closing edge it SHALL register result<=arith_y and sign<=(op==sub && a<b), then go to RESP.
REQ-023 arith_enable_low SHALL be 1 in IDLE and RESP; result SHALL never be sampled while the unit is disabled, so no X/Z reaches result.
REQ-024 In RESP, out_valid SHALL be 1, and result, sign and err SHALL be held stable until out_ready=1; on that edge the FSM SHALL go to IDLE and clear out_valid.
REQ-025 Latency: out_valid SHALL rise SETTLE+2 edges after the accepting edge for legal ops, and 1 edge after it for illegal ops.
REQ-026 No new request SHALL be accepted in the cycle that RESP completes; at most one request is in flight.
REQ-027 in_valid dropping, or a, b or opcode changing, after the accept SHALL have no effect on the in-flight operation.

Reset
REQ-028 On rst=1 at a clock edge, from any state including mid-DRIVE or RESP, the block SHALL enter IDLE.
REQ-029 Reset values SHALL be: in_ready=1 on the first post-reset cycle, out_valid=0, result=0, sign=0, err=0, arith_enable_low=1, arith_sel=00, arith_a=0, arith_b=0, counter=0.
REQ-030 A response pending at reset SHALL be discarded.

Configuration
REQ-031 Macro ALU_DIVZERO_TRAP_EN defined: opcode 0001 with b==0 SHALL skip DRIVE and go to RESP with err=1 and result=0.
REQ-032 Macro ALU_DIVZERO_TRAP_EN undefined: divide-by-zero SHALL be issued like any legal op, err=0, and result equal to whatever arith_y carries.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode constants (OP_DIV, OP_ADD, OP_SUB, OP_MUL), the arith_sel encodings and the FSM state enum.
REQ-034 Sub-module alu_op_decode SHALL be combinational, mapping opcode to {legal, arith_sel, is_sub, is_div}.
REQ-035 The arithmetic unit itself SHALL NOT be instantiated inside alu_issue_ctrl; the bench connects it.

Verification
REQ-036 add a=200, b=100, SETTLE=1 -> out_valid 3 edges after accept, result=16'd300, sign=0, err=0.
REQ-037 sub a=5, b=9 -> result=4, sign=1; sub a=9, b=9 -> result=0, sign=0.
REQ-038 mul a=255, b=255 -> result=16'hFE01; div a=100, b=7 -> result=14; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-039 opcode 4'b0101 -> err=1, result=0, 1-edge latency, arith_enable_low never 0; div b=0 with ALU_DIVZERO_TRAP_EN -> err=1, result=0.
REQ-040 rst pulsed during DRIVE -> next cycle IDLE, in_ready=1, arith_enable_low=1, out_valid=0; a following add 1+1 -> result=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_DIV = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0100;

  localparam logic [SEL_W-1:0] SEL_DIV = 2'b00;
  localparam logic [SEL_W-1:0] SEL_ADD = 2'b01;
  localparam logic [SEL_W-1:0] SEL_SUB = 2'b10;
  localparam logic [SEL_W-1:0] SEL_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: legality, arithmetic select and op flags.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  output logic             legal_c,
  output logic [SEL_W-1:0] sel_c,
  output logic             is_sub_c,
  output logic             is_div_c
);

  always_comb begin
    legal_c  = 1'b0;
    sel_c    = SEL_DIV;
    is_sub_c = 1'b0;
    is_div_c = 1'b0;
    case (opcode)
      OP_DIV: begin
        legal_c  = 1'b1;
        sel_c    = SEL_DIV;
        is_div_c = 1'b1;
      end
      OP_ADD: begin
        legal_c = 1'b1;
        sel_c   = SEL_ADD;
      end
      OP_SUB: begin
        legal_c  = 1'b1;
        sel_c    = SEL_SUB;
        is_sub_c = 1'b1;
      end
      OP_MUL: begin
        legal_c = 1'b1;
        sel_c   = SEL_MUL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external arithmetic unit and returns its result.
// Optional ALU_DIVZERO_TRAP_EN: divide with b==0 responds with err instead of issuing.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              sign,
  output logic              err,
  output logic [DATA_W-1:0] arith_a,
  output logic [DATA_W-1:0] arith_b,
  output logic [SEL_W-1:0]  arith_sel,
  output logic              arith_enable_low,
  input  logic [RES_W-1:0]  arith_y
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               is_sub, is_sub_nxt;
  logic               in_ready_nxt, out_valid_nxt, sign_nxt, err_nxt, enable_low_nxt;
  logic [RES_W-1:0]   result_nxt;
  logic [DATA_W-1:0]  arith_a_nxt, arith_b_nxt;
  logic [SEL_W-1:0]   arith_sel_nxt;

  logic               dec_legal_c, dec_is_sub_c, dec_is_div_c, trap_c;
  logic [SEL_W-1:0]   dec_sel_c;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .legal_c  (dec_legal_c),
    .sel_c    (dec_sel_c),
    .is_sub_c (dec_is_sub_c),
    .is_div_c (dec_is_div_c)
  );

`ifdef ALU_DIVZERO_TRAP_EN
  assign trap_c = dec_is_div_c && (b == '0);
`else
  logic div_unused;
  assign div_unused = dec_is_div_c;
  assign trap_c     = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    is_sub_nxt    = is_sub;
    result_nxt    = result;
    sign_nxt      = sign;
    err_nxt       = err;
    arith_a_nxt   = arith_a;
    arith_b_nxt   = arith_b;
    arith_sel_nxt = arith_sel;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (!dec_legal_c || trap_c) begin
            state_nxt  = RESP;
            err_nxt    = 1'b1;
            result_nxt = '0;
            sign_nxt   = 1'b0;
          end else begin
            state_nxt     = DRIVE;
            cnt_nxt       = '0;
            arith_a_nxt   = a;
            arith_b_nxt   = b;
            arith_sel_nxt = dec_sel_c;
            is_sub_nxt    = dec_is_sub_c;
          end
        end
      end
      DRIVE: begin
        if (cnt == CNT_W'(SETTLE - 1)) state_nxt = CAPTURE;
        else                           cnt_nxt   = cnt + CNT_W'(1);
      end
      CAPTURE: begin
        result_nxt = arith_y;
        sign_nxt   = is_sub && (arith_a < arith_b);
        err_nxt    = 1'b0;
        state_nxt  = RESP;
      end
      RESP: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt   = (state_nxt == IDLE);
    out_valid_nxt  = (state_nxt == RESP);
    enable_low_nxt = !((state_nxt == DRIVE) || (state_nxt == CAPTURE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      is_sub           <= 1'b0;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      result           <= '0;
      sign             <= 1'b0;
      err              <= 1'b0;
      arith_a          <= '0;
      arith_b          <= '0;
      arith_sel        <= SEL_DIV;
      arith_enable_low <= 1'b1;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      is_sub           <= is_sub_nxt;
      in_ready         <= in_ready_nxt;
      out_valid        <= out_valid_nxt;
      result           <= result_nxt;
      sign             <= sign_nxt;
      err              <= err_nxt;
      arith_a          <= arith_a_nxt;
      arith_b          <= arith_b_nxt;
      arith_sel        <= arith_sel_nxt;
      arith_enable_low <= enable_low_nxt;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural tri-stating arithmetic unit.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  opcode;
  logic [7:0]  a, b;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        sign, err;
  logic [7:0]  arith_a, arith_b;
  logic [1:0]  arith_sel;
  logic        arith_enable_low;
  wire  [15:0] arith_y;
  logic [15:0] unit_y;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .opcode           (opcode),
    .a                (a),
    .b                (b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .sign             (sign),
    .err              (err),
    .arith_a          (arith_a),
    .arith_b          (arith_b),
    .arith_sel        (arith_sel),
    .arith_enable_low (arith_enable_low),
    .arith_y          (arith_y)
  );

  // External arithmetic unit; sub returns the magnitude, div by zero returns all ones.
  always_comb begin
    case (arith_sel)
      2'b00:   unit_y = (arith_b == 8'd0) ? 16'hFFFF : 16'(arith_a / arith_b);
      2'b01:   unit_y = 16'(arith_a) + 16'(arith_b);
      2'b10:   unit_y = (arith_a >= arith_b) ? 16'(arith_a - arith_b) : 16'(arith_b - arith_a);
      default: unit_y = 16'(arith_a) * 16'(arith_b);
    endcase
  end
  assign arith_y = arith_enable_low ? 16'hzzzz : unit_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input int exp_lat, input logic [15:0] exp_res,
                        input logic exp_sign, input logic exp_err, input logic exp_legal,
                        input logic [1:0] exp_sel, input int hold);
    int  lat;
    logic en_seen;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = va; b = vb;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; opcode = 4'b0011; a = 8'hAA; b = 8'h55;
    lat = 1;
    en_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!arith_enable_low) en_seen = 1'b1;
      if (lat == 1 && exp_legal) begin
        check({name, "_sel"}, 32'(arith_sel), 32'(exp_sel));
        check({name, "_arith_a"}, 32'(arith_a), 32'(va));
        check({name, "_arith_b"}, 32'(arith_b), 32'(vb));
      end
      if (out_valid || lat >= 40) break;
      @(posedge clk);
      lat++;
    end
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_enable_used"}, 32'(en_seen), 32'(exp_legal));
    check({name, "_result"}, 32'(result), 32'(exp_res));
    check({name, "_sign"}, 32'(sign), 32'(exp_sign));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({name, "_hold_result"}, 32'(result), 32'(exp_res));
      check({name, "_hold_flags"}, {30'd0, sign, err}, {30'd0, exp_sign, exp_err});
    end
    @(negedge clk);
    check({name, "_resp_in_ready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_done_valid"}, 32'(out_valid), 32'd0);
    check({name, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; a = 8'd0; b = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {30'd0, sign, err}, 32'd0);
    check("rst_enable_low", 32'(arith_enable_low), 32'd1);
    check("rst_sel", 32'(arith_sel), 32'd0);
    check("rst_operands", {16'd0, arith_a, arith_b}, 32'd0);

    run_op("add",  4'b0010, 8'd200, 8'd100, 3, 16'd300,  1'b0, 1'b0, 1'b1, 2'b01, 0);
    run_op("sub_neg", 4'b0011, 8'd5, 8'd9,  3, 16'd4,    1'b1, 1'b0, 1'b1, 2'b10, 0);
    run_op("sub_eq",  4'b0011, 8'd9, 8'd9,  3, 16'd0,    1'b0, 1'b0, 1'b1, 2'b10, 0);
    run_op("mul",  4'b0100, 8'd255, 8'd255, 3, 16'hFE01, 1'b0, 1'b0, 1'b1, 2'b11, 0);
    run_op("div",  4'b0001, 8'd100, 8'd7,   3, 16'd14,   1'b0, 1'b0, 1'b1, 2'b00, 5);
    run_op("ill5", 4'b0101, 8'd3, 8'd4,     1, 16'd0,    1'b0, 1'b1, 1'b0, 2'b00, 1);
    run_op("ill0", 4'b0000, 8'd1, 8'd1,     1, 16'd0,    1'b0, 1'b1, 1'b0, 2'b00, 0);
`ifdef ALU_DIVZERO_TRAP_EN
    run_op("div0", 4'b0001, 8'd50, 8'd0,    1, 16'd0,    1'b0, 1'b1, 1'b0, 2'b00, 0);
`else
    run_op("div0", 4'b0001, 8'd50, 8'd0,    3, 16'hFFFF, 1'b0, 1'b0, 1'b1, 2'b00, 0);
`endif

    // Reset while the operation is in DRIVE.
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'b0010; a = 8'd3; b = 8'd4;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstdrv_in_ready", 32'(in_ready), 32'd1);
    check("rstdrv_enable_low", 32'(arith_enable_low), 32'd1);
    check("rstdrv_out_valid", 32'(out_valid), 32'd0);
    run_op("add_after_rst", 4'b0010, 8'd1, 8'd1, 3, 16'd2, 1'b0, 1'b0, 1'b1, 2'b01, 0);

    // Reset while a response is pending discards it.
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'b1111; a = 8'd0; b = 8'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pend_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstresp_out_valid", 32'(out_valid), 32'd0);
    check("rstresp_err", 32'(err), 32'd0);
    check("rstresp_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
